// File: rtl/prbs_pkg.sv
// prbs_pkg: shared modes, PRBS polynomial constants and the LFSR step.
// Used by prbs_scrambler and prbs_err_cnt.
package prbs_pkg;

  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,
    MODE_MSCR  = 2'b01,
    MODE_MDSCR = 2'b10,
    MODE_BYP   = 2'b11
  } mode_e;

  localparam logic [6:0]  PRBS7_TAPS  = 7'h60;
  localparam logic [6:0]  PRBS7_SEED  = '1;
  localparam logic [14:0] PRBS15_TAPS = 15'h6000;
  localparam logic [14:0] PRBS15_SEED = '1;
  localparam logic [22:0] PRBS23_TAPS = 23'h420000;
  localparam logic [22:0] PRBS23_SEED = '1;
  localparam logic [30:0] PRBS31_TAPS = 31'h48000000;
  localparam logic [30:0] PRBS31_SEED = '1;

  // Unrolled Fibonacci steps; bit 0 of data goes first.
  // Returns {next_state[31:0], out[63:0]}.
  function automatic logic [95:0] lfsr_step_n(
    input logic [31:0] state,
    input logic [63:0] data,
    input mode_e       mode,
    input int          len,
    input int          dw,
    input logic [31:0] taps
  );
    logic [31:0] s;
    logic [31:0] mask;
    logic [63:0] o;
    logic        fb;
    logic        x;
    mask = (len >= 32) ? '1 : ((32'd1 << len) - 32'd1);
    s    = state & mask;
    o    = '0;
    fb   = 1'b0;
    x    = 1'b0;
    for (int j = 0; j < 64; j++) begin
      if (j < dw) begin
        if (mode == MODE_BYP) begin
          o[j] = data[j];
        end else begin
          fb   = ^(s & taps);
          o[j] = data[j] ^ fb;
          case (mode)
            MODE_ADD:  x = fb;
            MODE_MSCR: x = o[j];
            default:   x = data[j];
          endcase
          s = ((s << 1) | {31'd0, x}) & mask;
        end
      end
    end
    return {s, o};
  endfunction

endpackage

// File: rtl/prbs_err_cnt.sv
// prbs_err_cnt: popcount of a checked beat into a
// saturating 16-bit error counter; clear wins over increment.
module prbs_err_cnt
  import prbs_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic [DW-1:0] data,
  input  logic          clr,
  output logic [15:0]   cnt
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [6:0]  pop;
  logic [16:0] sum;

  // Count ones, add, clamp at all-ones, clear has priority.
  always_comb begin
    pop = '0;
    for (int i = 0; i < DW; i++) begin
      pop = pop + {6'd0, data[i]};
    end
    sum   = {1'b0, cnt_q} + {10'd0, pop};
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prbs_scrambler.sv
// prbs_scrambler: additive / multiplicative LFSR scrambler with
// 1-cycle registered stream output. Checker: define SCR_PRBS_CHK_EN.
module prbs_scrambler
  import prbs_pkg::*;
#(
  parameter int             DW   = 8,
  parameter int             LEN  = 15,
  parameter logic [LEN-1:0] TAPS = 15'h6000,
  parameter logic [LEN-1:0] SEED = {LEN{1'b1}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     mode,
  input  logic           seed_load,
  input  logic [LEN-1:0] seed,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data
`ifdef SCR_PRBS_CHK_EN
  ,
  input  logic           err_clr,
  output logic [15:0]    err_cnt
`endif
);

  logic [LEN-1:0] state_q;
  logic [LEN-1:0] state_d;
  logic           out_valid_q;
  logic           out_valid_d;
  logic [DW-1:0]  out_data_q;
  logic [DW-1:0]  out_data_d;
  logic [LEN-1:0] start;
  logic [95:0]    step;
  logic           accept;
  logic           unused_step;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Seed select, DW-step keystream, stream register update.
  always_comb begin
    start = state_q;
    if (seed_load) begin
      start = (seed == '0) ? SEED : seed;
    end
    step = lfsr_step_n(32'(start), 64'(in_data), mode_e'(mode),
                       LEN, DW, 32'(TAPS));
    state_d     = start;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      state_d     = step[64 +: LEN];
      out_valid_d = 1'b1;
      out_data_d  = step[DW-1:0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign unused_step = ^step;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef SCR_PRBS_CHK_EN
  prbs_err_cnt #(.DW(DW)) u_err (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept && (mode == MODE_MDSCR)),
    .data (step[DW-1:0]),
    .clr  (err_clr),
    .cnt  (err_cnt)
  );
`endif

endmodule

// File: tb/tb_prbs_scrambler.sv
// tb_prbs_scrambler: directed vectors plus multi-cycle sequences
// for prbs_scrambler (default DW=8, LEN=15, x^15+x^14+1).
module tb_prbs_scrambler;

  logic        clk = 0;
  logic        rst;
  logic [1:0]  mode;
  logic        seed_load;
  logic [14:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  logic        d_ld;
  logic        d_in_ready;
  logic        d_out_valid;
  logic [7:0]  d_out_data;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SCR_PRBS_CHK_EN
  logic        err_clr;
  logic [15:0] err_cnt;
  logic        u_err_clr;
  logic [15:0] u_err_cnt;
`endif

  always #5 clk = ~clk;

  prbs_scrambler u_dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SCR_PRBS_CHK_EN
    ,
    .err_clr   (u_err_clr),
    .err_cnt   (u_err_cnt)
`endif
  );

  prbs_scrambler u_dsc (
    .clk       (clk),
    .rst       (rst),
    .mode      (2'b10),
    .seed_load (d_ld),
    .seed      (15'h1234),
    .in_valid  (out_valid && out_ready),
    .in_ready  (d_in_ready),
    .in_data   (out_data),
    .out_valid (d_out_valid),
    .out_ready (1'b1),
    .out_data  (d_out_data)
`ifdef SCR_PRBS_CHK_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  m;
    logic        ld;
    logic [14:0] sd;
    logic [7:0]  d;
    logic [7:0]  e;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Bit-serial reference: feedback = s[14]^s[13].
  task automatic mdl(input logic [14:0] si, input logic [7:0] d,
                     input logic [1:0] m, output logic [14:0] so,
                     output logic [7:0] o);
    logic [14:0] s;
    logic        f;
    logic        x;
    s = si;
    o = d;
    if (m != 2'b11) begin
      for (int j = 0; j < 8; j++) begin
        f    = s[14] ^ s[13];
        o[j] = d[j] ^ f;
        if (m == 2'b00)      x = f;
        else if (m == 2'b01) x = o[j];
        else                 x = d[j];
        s = {s[13:0], x};
      end
    end
    so = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; seed_load = 0; d_ld = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // One accepted beat with out_ready=1; result sampled #1 after edge.
  task automatic beat(input logic [1:0] m, input logic ld,
                      input logic [14:0] sd, input logic [7:0] d,
                      output logic [7:0] q, output logic v);
    mode = m; seed_load = ld; seed = sd; in_data = d; in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0; seed_load = 0;
    q = out_data; v = out_valid;
  endtask

  initial begin
    logic [14:0] ms;
    logic [7:0]  mo;
    logic [7:0]  q;
    logic        v;
    logic [7:0]  src[20];
    logic [7:0]  bp_d[10];
    logic [7:0]  expq[$];
    logic [7:0]  held;
    int          tx;
    int          rx;

    tbl[0] = '{2'b00, 1'b0, 15'h0, 8'h00, 8'h00};
    tbl[1] = '{2'b11, 1'b0, 15'h0, 8'hA5, 8'hA5};
    tbl[2] = '{2'b00, 1'b0, 15'h0, 8'h00, 8'h40};
    tbl[3] = '{2'b00, 1'b0, 15'h0, 8'h00, 8'h00};
    tbl[4] = '{2'b00, 1'b0, 15'h0, 8'h00, 8'h30};
    tbl[5] = '{2'b00, 1'b0, 15'h0, 8'hFF, 8'hFF};
    tbl[6] = '{2'b00, 1'b0, 15'h0, 8'h00, 8'h14};
    tbl[7] = '{2'b00, 1'b1, 15'h0, 8'h00, 8'h00};
    tbl[8] = '{2'b00, 1'b0, 15'h0, 8'h00, 8'h40};

    rst = 1; mode = 0; seed_load = 0; seed = 0; in_valid = 0;
    in_data = 0; out_ready = 1; d_ld = 0;
`ifdef SCR_PRBS_CHK_EN
    err_clr = 0; u_err_clr = 0;
`endif
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      beat(tbl[i].m, tbl[i].ld, tbl[i].sd, tbl[i].d, q, v);
      chk($sformatf("tbl%0d_valid", i), 32'(v), 32'd1);
      chk($sformatf("tbl%0d_data", i), 32'(q), 32'(tbl[i].e));
    end
    @(posedge clk); #1;
    chk("idle_valid_drop", 32'(out_valid), 32'd0);

    // Seed 0001 loaded with a beat, then free running.
    do_reset();
    ms = 15'h0001;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      mdl(ms, d, 2'b00, ms, mo);
      beat(2'b00, i == 0, 15'h0001, d, q, v);
      chk($sformatf("seed1_b%0d", i), 32'(q), 32'(mo));
    end

    // Reset while a beat is held.
    do_reset();
    out_ready = 0;
    beat(2'b00, 1'b0, 15'h0, 8'h00, q, v);
    chk("hold_valid", 32'(v), 32'd1);
    @(negedge clk);
    rst = 1; in_valid = 1; in_data = 8'hFF;
    @(posedge clk); #1;
    rst = 0; in_valid = 0; out_ready = 1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    beat(2'b00, 1'b0, 15'h0, 8'h00, q, v);
    chk("midrst_b0", 32'(q), 32'h00);
    beat(2'b00, 1'b0, 15'h0, 8'h00, q, v);
    chk("midrst_b1", 32'(q), 32'h40);

    // Backpressure: 10 beats, out_ready low 5 cycles.
    do_reset();
    ms = 15'h7FFF;
    for (int i = 0; i < 10; i++) bp_d[i] = 8'($urandom);
    tx = 0; rx = 0; held = 0;
    mode = 2'b00;
    for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = tx < 10;
      in_data   = bp_d[tx < 10 ? tx : 0];
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        if (cyc > 4) chk("bp_stable", 32'(out_data), 32'(held));
      end
      held = out_data;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_rx%0d", rx), 32'(out_data),
            32'(expq.pop_front()));
        rx++;
      end
      if (in_valid && in_ready) begin
        mdl(ms, bp_d[tx], 2'b00, ms, mo);
        expq.push_back(mo);
        tx++;
      end
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    chk("bp_count", 32'(rx), 32'd10);

    // Round trip through a descrambler with a different seed.
    do_reset();
    @(negedge clk); d_ld = 1;
    @(negedge clk); d_ld = 0;
    ms = 15'h7FFF;
    for (int i = 0; i < 20; i++) src[i] = 8'($urandom);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      mode = 2'b01;
      in_valid = c < 20;
      in_data  = src[c < 20 ? c : 0];
      @(posedge clk); #1;
      if (c < 20) begin
        mdl(ms, src[c], 2'b01, ms, mo);
        chk($sformatf("mscr_b%0d", c), 32'(out_data), 32'(mo));
      end
      if (c >= 3 && c <= 20)
        chk($sformatf("rt_b%0d", c - 1), 32'(d_out_data),
            32'(src[c - 1]));
    end
    in_valid = 0;

`ifdef SCR_PRBS_CHK_EN
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("err_clr0", 32'(err_cnt), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = 1;
      in_data  = (c == 4) ? 8'h03 : 8'h00;
    end
    @(negedge clk); in_valid = 0;
    repeat (3) @(negedge clk);
    chk("err_inc2", 32'(err_cnt), 32'd2);
    @(negedge clk);
    in_valid = 1; in_data = 8'hFF;
    @(posedge clk); #1;
    in_valid = 0; err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    chk("err_clr_prio", 32'(err_cnt), 32'd0);
    @(negedge clk);
    in_valid = 1; in_data = 8'hFF;
    repeat (8200) @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(negedge clk);
    chk("err_sat", 32'(err_cnt), 32'hFFFF);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("err_clr1", 32'(err_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs_scrambler.md
Name: prbs_scrambler

Overview:
- Parametrised LFSR scrambler/descrambler. It processes DW bits per beat using a generic Fibonacci polynomial of length LEN.
- Supports additive (frame-synchronous) mode, multiplicative (self-synchronising) scramble and descramble modes, and bypass.
- Sits between framing logic and the serdes/line interface, with a valid/ready stream on both sides.
- Has a registered output (1-cycle latency) and a runtime seed load.

Parameters:
- DW, 8, data bits per beat (1..64).
- LEN, 15, LFSR length (2..32).
- TAPS, 15'h6000, feedback mask: bit i set means s[i] is XORed into feedback. Default is x^15+x^14+1.
- SEED, {LEN{1'b1}}, reset state; also the substitute for an all-zero seed load. Must be non-zero.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- mode  input  2  00 additive, 01 multiplicative scramble, 10 multiplicative descramble, 11 bypass
- seed_load  input  1  load seed into LFSR this cycle
- seed  input  LEN  seed value
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid&&in_ready
- in_data  input  DW  input beat; bit 0 is processed first
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accepts
- out_data  output  DW  processed beat
- err_clr  input  1  clear error counter (only present with SCR_PRBS_CHK_EN)
- err_cnt  output  16  error counter (only present with SCR_PRBS_CHK_EN)

Behaviour:
- Reset (clk, rst sync active-high): state<=SEED, out_valid<=0, out_data<=0, err_cnt<=0. Reset mid-operation discards the held beat and ignores any same-cycle input.
- in_ready = !out_valid || out_ready (combinational). Stalls never lose or duplicate beats.
- Accept = in_valid&&in_ready. On accept, out_data <= f(in_data) and out_valid<=1. Otherwise, if out_ready, out_valid<=0. Latency is exactly 1 cycle; full throughput is 1 beat/cycle under out_ready=1.
- Per-bit step j=0..DW-1, fully unrolled within one cycle:
  - fb = ^(s & TAPS); o[j] = d[j]^fb.
  - Next s = {s[LEN-2:0], x}, where x = fb (additive), o[j] (mult scramble), or d[j] (mult descramble).
- The LFSR advances by DW steps only on accept. It holds otherwise, including during stalls.
- Bypass (11): o=d, state holds.
- mode is sampled per accepted beat. Changing mode mid-stream is legal; the state carries over unchanged.
- seed_load: state <= (seed==0 ? SEED : seed). If seed_load coincides with accept, the loaded value is the starting state for that beat's DW steps. The stored result is the state after those steps.
- The LFSR never holds zero in additive mode. Multiplicative modes may pass through zero legitimately.

Optional Feature:
- Macro: SCR_PRBS_CHK_EN.
- When defined:
  - err_cnt/err_clr exist.
  - On each accepted beat in mode 10, err_cnt adds popcount(o) (the checker expects an all-zero payload), saturating at 16'hFFFF.
  - err_clr zeroes the counter next cycle and takes priority over a same-cycle increment.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package prbs_pkg holds:
  - mode encodings (MODE_ADD, MODE_MSCR, MODE_MDSCR, MODE_BYP);
  - default TAPS/SEED constants for PRBS7/15/23/31;
  - a function lfsr_step_n(state, data, mode) returning {next_state, out}.
- One sub-module, prbs_err_cnt (popcount + saturating counter), is instantiated only under SCR_PRBS_CHK_EN.

Test Plan:
- Additive, default params, reset, in_data=8'h00 for two beats, out_ready=1 -> out_data 8'h00 then 8'h40, each 1 cycle after accept.
- Round trip: mult scramble of random stream into a second instance in mult descramble with different seed -> descrambler output matches input from beat 2 onward (self-sync within LEN=15 bits).
- Backpressure: out_ready low for 5 cycles mid-stream of 10 beats -> in_ready low while out_valid held, out_data stable, no loss/duplication, keystream continuous versus golden model.
- seed_load with seed=0 concurrent with accept in additive mode -> state uses SEED 15'h7FFF, that beat's output 8'h00. A load of 15'h0001 gives a golden-model match.
- Bypass beat 8'hA5 -> out 8'hA5, LFSR state unchanged (the next additive beat equals the no-bypass sequence). rst asserted while out_valid=1 -> out_valid 0 next cycle, state=SEED.
- With SCR_PRBS_CHK_EN: mode 10 after sync, inject in_data=8'h03 error -> err_cnt increments by 2 per affected output bit count. The counter saturates at 16'hFFFF; err_clr -> 0.
